mon_stream_rx: RTL and testbench

Receiving end of the monitor-channel serial stream. Captures the gated RWI-bit word stream emitted by a monitor-channel chain, one frame of NCHAN words per samp event, and assembles it into a double-buffered result bank. A host or local-bus reader fetches the bank by address, with a valid/ack handshake and overrun and frame-error flags.

---
 rtl/mon_stream_rx_pkg.sv | 19 +
 rtl/mon_stream_rx_if.sv | 29 ++
 rtl/mon_bank_pp.sv | 64 ++++++
 rtl/mon_stream_rx.sv | 121 ++++++++++++
 tb/tb_mon_stream_rx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mon_stream_rx_pkg.sv
// Shared definitions for the monitor-channel stream receiver: FSM encoding,
// read-miss value and index-width helper.
package mon_stream_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

  // Value returned for read addresses beyond the frame length.
  localparam int RD_MISS = 0;

  // wr_idx must be able to hold NCHAN itself (saturated "full" count).
  function automatic int idx_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mon_stream_rx_if.sv
// Stream input, read port, handshake and error flags of the stream receiver.
// master = stream source / bus reader side, slave = receiver.
interface mon_stream_rx_if #(
  parameter int RWI = 28,
  parameter int AW  = 2
);

  logic                  samp;
  logic signed [RWI-1:0] s_in;
  logic                  g_in;
  logic [AW-1:0]         rd_addr;
  logic signed [RWI-1:0] rd_data;
  logic                  valid;
  logic                  ack;
  logic                  overrun;
  logic                  frame_err;
  logic                  clr_err;

  modport master (
    output samp, s_in, g_in, rd_addr, ack, clr_err,
    input  rd_data, valid, overrun, frame_err
  );

  modport slave (
    input  samp, s_in, g_in, rd_addr, ack, clr_err,
    output rd_data, valid, overrun, frame_err
  );

endinterface

// File: rtl/mon_bank_pp.sv
// Ping-pong register bank: one half captures while the other is published.
// swap exchanges roles; a write in the swap cycle lands in the new capture half.
module mon_bank_pp
  import mon_stream_rx_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int RWI   = 28,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic signed [RWI-1:0] wr_data,
  input  logic                  swap,
  input  logic [AW-1:0]         rd_addr,
  output logic signed [RWI-1:0] rd_data
);

  localparam int DEPTH = 2 ** AW;

  logic                  pub_sel_reg;
  logic                  cap_sel;
  logic                  rd_hit;
  logic signed [RWI-1:0] rd_word [2];

  assign cap_sel = swap ? pub_sel_reg : ~pub_sel_reg;
  assign rd_hit  = ({1'b0, rd_addr} < (AW + 1)'(NCHAN));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic signed [RWI-1:0] mem [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && (cap_sel == 1'(gi))) begin
          mem[wr_addr] <= wr_data;
        end
      end

      assign rd_word[gi] = mem[rd_addr];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pub_sel_reg <= 1'b0;
    end else if (swap) begin
      pub_sel_reg <= ~pub_sel_reg;
    end
  end

  // Read uses the pre-swap selection, so a publish edge still returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_hit ? rd_word[pub_sel_reg] : RWI'(RD_MISS);
    end
  end

endmodule

// File: rtl/mon_stream_rx.sv
// Monitor-channel stream receiver: frames NCHAN gated words per samp into a
// ping-pong bank, publishes with valid/ack and tracks overrun / frame errors.
module mon_stream_rx
  import mon_stream_rx_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int RWI   = 28,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mon_stream_rx_if.slave  bus
);

  localparam int            IW       = idx_width(NCHAN);
  localparam logic [IW-1:0] FULL_IDX = IW'(NCHAN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHAN - 1);

  rx_state_e     state_reg, state_next;
  logic [IW-1:0] wr_idx_reg, wr_idx_next;
  logic          valid_reg, valid_next;
  logic          overrun_reg, frame_err_reg;
  logic          wr_en, swap, start, ovr_set, ferr_set;
  logic [AW-1:0] wr_addr;

  always_comb begin
    state_next  = state_reg;
    wr_idx_next = wr_idx_reg;
    wr_en       = 1'b0;
    wr_addr     = AW'(wr_idx_reg);
    swap        = 1'b0;
    start       = 1'b0;
    ovr_set     = 1'b0;
    ferr_set    = 1'b0;
    valid_next  = valid_reg & ~bus.ack;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.samp) begin
          start = 1'b1;
        end else if (bus.g_in) begin
          ferr_set = 1'b1;
        end
      end
      ST_CAPT: begin
        if (bus.samp) begin
          ferr_set = (wr_idx_reg < FULL_IDX);
          start    = 1'b1;
        end else if (bus.g_in && (wr_idx_reg < FULL_IDX)) begin
          wr_en       = 1'b1;
          wr_idx_next = wr_idx_reg + 1'b1;
          if (wr_idx_reg == LAST_IDX) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        // An ack in this same cycle frees the published slot for the new frame.
        if (!valid_reg || bus.ack) begin
          swap       = 1'b1;
          valid_next = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
        if (bus.samp) begin
          start = 1'b1;
        end else if (bus.g_in) begin
          ferr_set = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A word arriving with samp is word 0 of the new frame.
    if (start) begin
      state_next  = ST_CAPT;
      wr_idx_next = '0;
      wr_addr     = '0;
      if (bus.g_in) begin
        wr_en       = 1'b1;
        wr_idx_next = IW'(1);
        if (NCHAN == 1) state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_idx_reg    <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_idx_reg    <= wr_idx_next;
      valid_reg     <= valid_next;
      overrun_reg   <= ovr_set  | (overrun_reg   & ~bus.clr_err);
      frame_err_reg <= ferr_set | (frame_err_reg & ~bus.clr_err);
    end
  end

  assign bus.valid     = valid_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = frame_err_reg;

  mon_bank_pp #(
    .NCHAN (NCHAN),
    .RWI   (RWI),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.s_in),
    .swap    (swap),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_mon_stream_rx.sv
// Bench for mon_stream_rx: vector table, directed corner sequences and random
// traffic, all compared against a frame-level queue model.
module tb_mon_stream_rx;

  localparam int NCHAN = 4;
  localparam int RWI   = 28;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mon_stream_rx_if #(.RWI(RWI), .AW(AW)) bus ();

  mon_stream_rx #(.NCHAN(NCHAN), .RWI(RWI), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model: words collected in a queue, frames published whole.
  logic [RWI-1:0] m_pub [2**AW];
  logic [RWI-1:0] m_cur [$];
  logic [RWI-1:0] m_done [$];
  bit             m_capt, m_pend, m_valid, m_ovr, m_ferr;
  logic [RWI-1:0] m_rd;

  typedef struct {
    bit             samp;
    bit             g;
    logic [RWI-1:0] s;
    bit             ack;
    bit             clr;
    logic [AW-1:0]  addr;
    bit             ev;
    bit             eo;
    bit             ef;
    bit             chk_rd;
    logic [RWI-1:0] erd;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit samp, bit g, logic [RWI-1:0] s, bit ack, bit clr,
                              logic [AW-1:0] addr, bit ev, bit eo, bit ef,
                              bit chk_rd, logic [RWI-1:0] erd);
    vec_t v;
    v.samp = samp; v.g = g; v.s = s; v.ack = ack; v.clr = clr; v.addr = addr;
    v.ev = ev; v.eo = eo; v.ef = ef; v.chk_rd = chk_rd; v.erd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [RWI-1:0] act, input logic [RWI-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) m_pub[i] = '0;
    m_cur.delete();
    m_done.delete();
    m_capt = 0; m_pend = 0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_rd = '0;
  endtask

  task automatic model_step(input bit samp, input bit g, input logic [RWI-1:0] s,
                            input bit ack, input bit clr, input logic [AW-1:0] addr);
    bit ferr_ev;
    bit ovr_ev;
    ferr_ev = 0;
    ovr_ev  = 0;
    m_rd = (int'(addr) < NCHAN) ? m_pub[addr] : '0;
    if (m_pend) begin
      m_pend = 0;
      if (m_valid && !ack) begin
        ovr_ev = 1;
      end else begin
        for (int i = 0; i < NCHAN; i++) m_pub[i] = m_done[i];
        m_valid = 1;
      end
    end else if (ack) begin
      m_valid = 0;
    end
    if (samp) begin
      if (m_capt) ferr_ev = 1;
      m_cur.delete();
      m_capt = 1;
      if (g) m_cur.push_back(s);
    end else if (g) begin
      if (m_capt) m_cur.push_back(s);
      else        ferr_ev = 1;
    end
    if (m_capt && (m_cur.size() == NCHAN)) begin
      m_done = m_cur;
      m_pend = 1;
      m_capt = 0;
    end
    m_ovr  = ovr_ev  | (m_ovr  & ~clr);
    m_ferr = ferr_ev | (m_ferr & ~clr);
  endtask

  task automatic cyc(input bit samp, input bit g, input logic [RWI-1:0] s,
                     input bit ack, input bit clr, input logic [AW-1:0] addr);
    bus.samp = samp; bus.g_in = g; bus.s_in = s;
    bus.ack = ack; bus.clr_err = clr; bus.rd_addr = addr;
    @(posedge clk);
    model_step(samp, g, s, ack, clr, addr);
    #1;
    check("mdl_rd_data",   bus.rd_data,   m_rd);
    check("mdl_valid",     bus.valid,     m_valid);
    check("mdl_overrun",   bus.overrun,   m_ovr);
    check("mdl_frame_err", bus.frame_err, m_ferr);
  endtask

  task automatic idle(input logic [AW-1:0] addr);
    cyc(0, 0, '0, 0, 0, addr);
  endtask

  task automatic expect_flags(input string tag, input bit v, input bit o, input bit f);
    check({tag, "_valid"},     bus.valid,     v);
    check({tag, "_overrun"},   bus.overrun,   o);
    check({tag, "_frame_err"}, bus.frame_err, f);
  endtask

  // samp, NCHAN consecutive words base+1.., then the DONE cycle.
  task automatic send_frame(input logic [RWI-1:0] base, input bit ack_done, input bit samp_done);
    cyc(1, 0, '0, 0, 0, '0);
    for (int k = 1; k <= NCHAN; k++) cyc(0, 1, base + RWI'(k), 0, 0, '0);
    cyc(samp_done, 0, '0, ack_done, 0, '0);
  endtask

  task automatic read_frame(input string tag, input logic [RWI-1:0] base);
    for (int k = 0; k < NCHAN; k++) begin
      idle(AW'(k));
      check({tag, "_rd"}, bus.rd_data, base + RWI'(k + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.samp = 0; bus.g_in = 0; bus.s_in = '0; bus.ack = 0; bus.clr_err = 0; bus.rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("reset_rd_data", bus.rd_data, '0);
    expect_flags("reset", 0, 0, 0);

    // Nominal frame, reads, ack behaviour.
    tbl.push_back(mk(1, 0, 28'h0,       0, 0, 3'd0, 0, 0, 0, 1, 28'h0));
    tbl.push_back(mk(0, 1, 28'h1000001, 0, 0, 3'd0, 0, 0, 0, 1, 28'h0));
    tbl.push_back(mk(0, 1, 28'h1000002, 0, 0, 3'd0, 0, 0, 0, 0, 28'h0));
    tbl.push_back(mk(0, 1, 28'h1000003, 0, 0, 3'd0, 0, 0, 0, 0, 28'h0));
    tbl.push_back(mk(0, 1, 28'h1000004, 0, 0, 3'd0, 0, 0, 0, 0, 28'h0));
    tbl.push_back(mk(0, 0, 28'h0,       0, 0, 3'd0, 1, 0, 0, 1, 28'h0));
    tbl.push_back(mk(0, 0, 28'h0,       0, 0, 3'd0, 1, 0, 0, 1, 28'h1000001));
    tbl.push_back(mk(0, 0, 28'h0,       0, 0, 3'd1, 1, 0, 0, 1, 28'h1000002));
    tbl.push_back(mk(0, 0, 28'h0,       0, 0, 3'd2, 1, 0, 0, 1, 28'h1000003));
    tbl.push_back(mk(0, 0, 28'h0,       0, 0, 3'd3, 1, 0, 0, 1, 28'h1000004));
    tbl.push_back(mk(0, 0, 28'h0,       0, 0, 3'd7, 1, 0, 0, 1, 28'h0));
    tbl.push_back(mk(0, 0, 28'h0,       1, 0, 3'd3, 0, 0, 0, 1, 28'h1000004));
    tbl.push_back(mk(0, 0, 28'h0,       1, 0, 3'd0, 0, 0, 0, 0, 28'h0));
    tbl.push_back(mk(0, 0, 28'h0,       0, 1, 3'd0, 0, 0, 0, 0, 28'h0));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].samp, tbl[i].g, tbl[i].s, tbl[i].ack, tbl[i].clr, tbl[i].addr);
      expect_flags($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].ef);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rd", i), bus.rd_data, tbl[i].erd);
    end

    // Gapped gate: three idle cycles between words.
    cyc(1, 0, '0, 0, 0, '0);
    for (int k = 1; k <= NCHAN; k++) begin
      cyc(0, 1, 28'h1000000 + RWI'(k), 0, 0, '0);
      if (k < NCHAN) repeat (3) idle('0);
    end
    expect_flags("gap_last", 0, 0, 0);
    idle('0);
    expect_flags("gap_pub", 1, 0, 0);
    read_frame("gap", 28'h1000000);
    cyc(0, 0, '0, 1, 0, '0);

    // Overrun: A unacked, B dropped, then C after ack.
    send_frame(28'h10, 0, 0);
    expect_flags("ovr_a", 1, 0, 0);
    send_frame(28'h20, 0, 0);
    expect_flags("ovr_b", 1, 1, 0);
    read_frame("ovr_keep_a", 28'h10);
    cyc(0, 0, '0, 1, 0, '0);
    expect_flags("ovr_ack", 0, 1, 0);
    send_frame(28'h30, 0, 0);
    expect_flags("ovr_c", 1, 1, 0);
    read_frame("ovr_c", 28'h30);
    cyc(0, 0, '0, 1, 1, '0);
    expect_flags("ovr_clr", 0, 0, 0);

    // Short frame: 2 words then samp.
    cyc(1, 0, '0, 0, 0, '0);
    cyc(0, 1, 28'h3a, 0, 0, '0);
    cyc(0, 1, 28'h3b, 0, 0, '0);
    send_frame(28'h40, 0, 0);
    expect_flags("short", 1, 0, 1);
    read_frame("short", 28'h40);
    cyc(0, 0, '0, 1, 1, '0);
    expect_flags("short_clr", 0, 0, 0);

    // Long frame: extra gated word after DONE.
    send_frame(28'h50, 0, 0);
    cyc(0, 1, 28'h5f, 0, 0, '0);
    expect_flags("long", 1, 0, 1);
    read_frame("long", 28'h50);
    cyc(0, 0, '0, 1, 1, '0);
    expect_flags("long_clr", 0, 0, 0);

    // Collisions: ack in DONE, then samp in DONE.
    send_frame(28'h60, 0, 0);
    send_frame(28'h70, 1, 0);
    expect_flags("ack_done", 1, 0, 0);
    read_frame("ack_done", 28'h70);
    send_frame(28'h80, 1, 1);
    expect_flags("samp_done", 1, 0, 0);
    for (int k = 1; k <= NCHAN; k++) cyc(0, 1, 28'h90 + RWI'(k), 0, 0, '0);
    cyc(0, 0, '0, 1, 0, '0);
    expect_flags("samp_done_pub", 1, 0, 0);
    read_frame("samp_done", 28'h90);

    // Asynchronous reset in the middle of a frame.
    cyc(1, 0, '0, 0, 0, '0);
    cyc(0, 1, 28'hb1, 0, 0, '0);
    cyc(0, 1, 28'hb2, 0, 0, '0);
    check("pre_rst_rd", bus.rd_data, 28'h91);
    bus.samp = 0; bus.g_in = 0; bus.ack = 0; bus.clr_err = 0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_rd", bus.rd_data, '0);
    expect_flags("async_rst", 0, 0, 0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    send_frame(28'ha0, 0, 0);
    expect_flags("post_rst", 1, 0, 0);
    read_frame("post_rst", 28'ha0);
    idle(3'd7);
    check("rd_miss", bus.rd_data, '0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6, RWI'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, AW'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
